// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: fetch-side queue between PC gen / IMEM and the IF/ID register.
// Issues in-order fetch requests, tags each with its address and prediction flag,
// pairs in-order responses with those tags and buffers them for decode.
// A flush clears everything buffered and discards responses still in flight.
// Optional build macro IFQ_BYPASS_EN: a response arriving into an empty buffer
// drives the outputs in the same cycle and, when not stalled, skips the buffer.
module ifu_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_pred_i,
  output logic              fetch_ready_o,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              flush_flag_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              is_pred_branch_o,
  output logic              inst_valid_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DEPTH-1:0]  buf_pred;
  logic [ADDR_W-1:0] tag_addr [DEPTH];
  logic [DEPTH-1:0]  tag_pred;

  logic [PTR_W-1:0] buf_wr_ptr, buf_rd_ptr, tag_wr_ptr, tag_rd_ptr;
  logic [CNT_W-1:0] occupancy, inflight, discard;
  logic [CNT_W+1:0] total;

  logic credit, issue_ok, fetch_fire;
  logic rsp_take, rsp_drop, rsp_live, buf_empty;
  logic bypass_hit, head_valid, buf_push, buf_pop;

  // Every slot is reserved at request time, so a response can never overflow the buffer.
  assign total      = {2'b00, occupancy} + {2'b00, inflight} + {2'b00, discard};
  assign credit     = total < (CNT_W + 2)'(DEPTH);
  assign issue_ok   = credit & !flush_flag_i & rst_n;
  assign req_valid_o   = fetch_valid_i & issue_ok;
  assign fetch_ready_o = req_ready_i & issue_ok;
  assign req_addr_o    = fetch_addr_i;
  assign fetch_fire    = fetch_valid_i & fetch_ready_o;

  assign buf_empty = (occupancy == '0);
  assign rsp_drop  = rsp_valid_i & (discard != '0);
  assign rsp_take  = rsp_valid_i & !flush_flag_i & (discard == '0) & (inflight != '0);
  assign rsp_live  = rsp_valid_i & ((discard != '0) | (inflight != '0));

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = rsp_take & buf_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_valid = !buf_empty | bypass_hit;
  assign buf_pop    = !buf_empty & !stall_i & !flush_flag_i;
  assign buf_push   = rsp_take & !(bypass_hit & !stall_i);

  // Counters and pointers; flush clears the queues and converts in-flight fetches into discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy  <= '0;
      inflight   <= '0;
      discard    <= '0;
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else if (flush_flag_i) begin
      occupancy  <= '0;
      inflight   <= '0;
      discard    <= discard + inflight - CNT_W'(rsp_live);
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      occupancy  <= occupancy + CNT_W'(buf_push) - CNT_W'(buf_pop);
      inflight   <= inflight + CNT_W'(fetch_fire) - CNT_W'(rsp_take);
      discard    <= discard - CNT_W'(rsp_drop);
      buf_wr_ptr <= buf_wr_ptr + PTR_W'(buf_push);
      buf_rd_ptr <= buf_rd_ptr + PTR_W'(buf_pop);
      tag_wr_ptr <= tag_wr_ptr + PTR_W'(fetch_fire);
      tag_rd_ptr <= tag_rd_ptr + PTR_W'(rsp_take);
    end
  end

  // Storage arrays need no reset: the counters decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      tag_addr[tag_wr_ptr] <= fetch_addr_i;
      tag_pred[tag_wr_ptr] <= fetch_pred_i;
    end
    if (buf_push) begin
      buf_data[buf_wr_ptr] <= rsp_data_i;
      buf_addr[buf_wr_ptr] <= tag_addr[tag_rd_ptr];
      buf_pred[buf_wr_ptr] <= tag_pred[tag_rd_ptr];
    end
  end

  // Present the buffer head (or a bypassed response) and NOP-fill when nothing is valid.
  always_comb begin
    inst_o           = {(DATA_W / 32){INST_NOP}};
    inst_addr_o      = '0;
    is_pred_branch_o = 1'b0;
    inst_valid_o     = head_valid;
    if (!buf_empty) begin
      inst_o           = buf_data[buf_rd_ptr];
      inst_addr_o      = buf_addr[buf_rd_ptr];
      is_pred_branch_o = buf_pred[buf_rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass_hit) begin
      inst_o           = rsp_data_i;
      inst_addr_o      = tag_addr[tag_rd_ptr];
      is_pred_branch_o = tag_pred[tag_rd_ptr];
    end
`endif
  end

  // A response with nothing outstanding means IMEM broke the in-order contract.
  rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid_i && inflight == '0 && discard == '0));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed bench for ifu_fetch_queue (DEPTH=4, DATA_W=64, ADDR_W=32).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ifu_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] NOP2 = {32'h0000_0013, 32'h0000_0013};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_addr_i = '0;
  logic        fetch_pred_i = 1'b0;
  logic        fetch_ready_o;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [63:0] rsp_data_i = '0;
  logic        flush_flag_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [63:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        is_pred_branch_o;
  logic        inst_valid_o;
  logic [97:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch_queue #(.DEPTH(4), .DATA_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid_i), .fetch_addr_i(fetch_addr_i), .fetch_pred_i(fetch_pred_i),
    .fetch_ready_o(fetch_ready_o),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .flush_flag_i(flush_flag_i), .stall_i(stall_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .is_pred_branch_o(is_pred_branch_o), .inst_valid_o(inst_valid_o)
  );

  assign obs = {inst_valid_o, inst_addr_o, is_pred_branch_o, inst_o};

  // Fetch word the IMEM model returns for a given address.
  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {32'hC0DE_0000 ^ a, ~a};
  endfunction

  // Expected {valid, addr, pred, inst} bundle at the decode-side outputs.
  function automatic logic [97:0] exp_out(input bit v, input logic [31:0] a, input bit p);
    return v ? {1'b1, a, p, data_of(a)} : {1'b0, 32'h0, 1'b0, NOP2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_valid_i = 1'b1; fetch_addr_i = 32'h80; req_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_ready got %b want 0", fetch_ready_o); end
    checks++; if (req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %b want 0", req_valid_o); end
    checks++; if (obs !== exp_out(0, 0, 0)) begin errors++; $display("[TB] FAIL reset_outputs got %h want %h", obs, exp_out(0, 0, 0)); end
    fetch_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b want 1", fetch_ready_o); end
    step();
  endtask

  task automatic test_basic();
    stall_i = 1'b0; req_ready_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h100; fetch_pred_i = 1'b0;
    @(negedge clk);
    checks++; if ({req_valid_o, req_addr_o} !== {1'b1, 32'h100}) begin errors++; $display("[TB] FAIL basic_req0 got %b/%h want 1/100", req_valid_o, req_addr_o); end
    step();
    fetch_addr_i = 32'h108; fetch_pred_i = 1'b1;
    @(negedge clk);
    checks++; if ({req_valid_o, req_addr_o} !== {1'b1, 32'h108}) begin errors++; $display("[TB] FAIL basic_req1 got %b/%h want 1/108", req_valid_o, req_addr_o); end
    step();
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h100);
    @(negedge clk);
    checks++; if (obs !== exp_out(BYP, 32'h100, 0)) begin errors++; $display("[TB] FAIL basic_rsp0_cycle got %h want %h", obs, exp_out(BYP, 32'h100, 0)); end
    step();
    rsp_data_i = data_of(32'h108);
    @(negedge clk);
    checks++; if (obs !== (BYP ? exp_out(1, 32'h108, 1) : exp_out(1, 32'h100, 0))) begin errors++; $display("[TB] FAIL basic_out0 got %h", obs); end
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(!BYP, 32'h108, 1)) begin errors++; $display("[TB] FAIL basic_out1 got %h want %h", obs, exp_out(!BYP, 32'h108, 1)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(0, 0, 0)) begin errors++; $display("[TB] FAIL basic_empty got %h want %h", obs, exp_out(0, 0, 0)); end
    step();
  endtask

  task automatic test_full_and_swap();
    stall_i = 1'b1; req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_valid_i = 1'b1; fetch_addr_i = 32'h300 + 32'(8 * i); fetch_pred_i = i[0];
      @(negedge clk);
      checks++; if (fetch_ready_o !== (i < 4)) begin errors++; $display("[TB] FAIL full_issue%0d got %b want %b", i, fetch_ready_o, (i < 4)); end
      step();
    end
    fetch_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h300 + 32'(8 * i));
      @(negedge clk);
      checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_rsp%0d_ready got %b want 0", i, fetch_ready_o); end
      step();
    end
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h300, 0)) begin errors++; $display("[TB] FAIL full_head got %h want %h", obs, exp_out(1, 32'h300, 0)); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_no_credit got %b want 0", fetch_ready_o); end
    step();
    stall_i = 1'b0;
    @(negedge clk);
    step();
    stall_i = 1'b1; fetch_valid_i = 1'b1; fetch_addr_i = 32'h320; fetch_pred_i = 1'b1;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL swap_credit got %b want 1", fetch_ready_o); end
    checks++; if (obs !== exp_out(1, 32'h308, 1)) begin errors++; $display("[TB] FAIL swap_head got %h want %h", obs, exp_out(1, 32'h308, 1)); end
    step();
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h320); stall_i = 1'b0;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL swap_full_ready got %b want 0", fetch_ready_o); end
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h310, 0)) begin errors++; $display("[TB] FAIL swap_drain0 got %h want %h", obs, exp_out(1, 32'h310, 0)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h318, 1)) begin errors++; $display("[TB] FAIL swap_drain1 got %h want %h", obs, exp_out(1, 32'h318, 1)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h320, 1)) begin errors++; $display("[TB] FAIL swap_drain2 got %h want %h", obs, exp_out(1, 32'h320, 1)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(0, 0, 0)) begin errors++; $display("[TB] FAIL swap_empty got %h want %h", obs, exp_out(0, 0, 0)); end
    step();
  endtask

  task automatic test_flush_inflight();
    stall_i = 1'b0; req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_valid_i = 1'b1; fetch_addr_i = 32'h400 + 32'(8 * i); fetch_pred_i = i[0];
      @(negedge clk);
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_issue%0d got %b want 1", i, fetch_ready_o); end
      step();
    end
    fetch_addr_i = 32'h500; flush_flag_i = 1'b1;
    @(negedge clk);
    checks++; if ({req_valid_o, fetch_ready_o} !== 2'b00) begin errors++; $display("[TB] FAIL flush_blocks_req got %b%b want 00", req_valid_o, fetch_ready_o); end
    step();
    flush_flag_i = 1'b0; fetch_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h400 + 32'(8 * i));
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop%0d got %b want 0", i, inst_valid_o); end
      step();
    end
    rsp_valid_i = 1'b0; fetch_valid_i = 1'b1; fetch_addr_i = 32'h200; fetch_pred_i = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_after_drop got %b want 0", inst_valid_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_refetch got %b want 1", fetch_ready_o); end
    step();
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h200);
    @(negedge clk);
    checks++; if (obs !== exp_out(BYP, 32'h200, 0)) begin errors++; $display("[TB] FAIL flush_new_rsp got %h want %h", obs, exp_out(BYP, 32'h200, 0)); end
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(!BYP, 32'h200, 0)) begin errors++; $display("[TB] FAIL flush_new_out got %h want %h", obs, exp_out(!BYP, 32'h200, 0)); end
    step();
  endtask

  task automatic test_flush_with_rsp();
    stall_i = 1'b1; req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_valid_i = 1'b1; fetch_addr_i = 32'h600 + 32'(8 * i); fetch_pred_i = 1'b0;
      step();
    end
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h600);
    step();
    rsp_data_i = data_of(32'h608); flush_flag_i = 1'b1;
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h600, 0)) begin errors++; $display("[TB] FAIL frsp_flush_cycle got %h want %h", obs, exp_out(1, 32'h600, 0)); end
    step();
    flush_flag_i = 1'b0; rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid_i = 1'b1; fetch_addr_i = 32'h700 + 32'(8 * i); fetch_pred_i = !i[0];
      @(negedge clk);
      if (i == 0) begin
        checks++; if (obs !== exp_out(0, 0, 0)) begin errors++; $display("[TB] FAIL frsp_cleared got %h want %h", obs, exp_out(0, 0, 0)); end
      end
      checks++; if (fetch_ready_o !== (i < 2)) begin errors++; $display("[TB] FAIL frsp_credit%0d got %b want %b", i, fetch_ready_o, (i < 2)); end
      step();
    end
    fetch_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h610 + 32'(8 * i));
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL frsp_drop%0d got %b want 0", i, inst_valid_o); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h700 + 32'(8 * i));
      step();
    end
    rsp_valid_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h700, 1)) begin errors++; $display("[TB] FAIL frsp_out0 got %h want %h", obs, exp_out(1, 32'h700, 1)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'h708, 0)) begin errors++; $display("[TB] FAIL frsp_out1 got %h want %h", obs, exp_out(1, 32'h708, 0)); end
    step();
    @(negedge clk);
    checks++; if (obs !== exp_out(0, 0, 0)) begin errors++; $display("[TB] FAIL frsp_empty got %h want %h", obs, exp_out(0, 0, 0)); end
    step();
  endtask

  task automatic test_latency();
    stall_i = 1'b0; req_ready_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h40; fetch_pred_i = 1'b1;
    step();
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'h40);
    @(negedge clk);
    checks++; if (obs !== exp_out(BYP, 32'h40, 1)) begin errors++; $display("[TB] FAIL lat_same_cycle got %h want %h", obs, exp_out(BYP, 32'h40, 1)); end
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(!BYP, 32'h40, 1)) begin errors++; $display("[TB] FAIL lat_next_cycle got %h want %h", obs, exp_out(!BYP, 32'h40, 1)); end
    step();
  endtask

  task automatic test_reset_midflight();
    stall_i = 1'b1; req_ready_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_addr_i = 32'h900; fetch_pred_i = 1'b1;
    step();
    fetch_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({fetch_ready_o, obs} !== {1'b0, exp_out(0, 0, 0)}) begin errors++; $display("[TB] FAIL midreset_outputs got %b/%h", fetch_ready_o, obs); end
    step();
    rst_n = 1'b1; fetch_valid_i = 1'b1; fetch_addr_i = 32'hA00; fetch_pred_i = 1'b0;
    step();
    fetch_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data_of(32'hA00);
    step();
    rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (obs !== exp_out(1, 32'hA00, 0)) begin errors++; $display("[TB] FAIL midreset_pairing got %h want %h", obs, exp_out(1, 32'hA00, 0)); end
    stall_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_and_swap();
    test_flush_inflight();
    test_flush_with_rsp();
    test_latency();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
